// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
//   Generates VGA raster timing from the board clock. A clock divider produces a
//   one-cycle pixel_tick every CLK_DIV clocks; horizontal and vertical counters
//   step on that tick. Two phase FSMs (active / front porch / sync / back porch)
//   drive the sync outputs. Sync and video_on outputs are registered and are
//   decoded from next-state values, so they change on the same edge as the
//   coordinates.
//
// Ports
//   Clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   1 = run, 0 = freeze counters/phases and blank video
//   pixel_tick   out  one-Clk pulse every CLK_DIV cycles while enabled
//   pixel_x      out  horizontal count, 0..H_TOTAL-1
//   pixel_y      out  vertical count, 0..V_TOTAL-1
//   hsync/vsync  out  sync pulses, level SYNC_POL while asserted
//   video_on     out  inside the visible window and enabled
//   line_end     out  tick cycle of the last pixel of a line
//   frame_start  out  tick cycle of pixel (0,0)
module vga_timing_ctrl #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        enable,
  output logic        pixel_tick,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_end,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST      = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_FP_START  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYN_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_BP_START  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST      = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_FP_START  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYN_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_BP_START  = 11'(V_ACTIVE + V_FP + V_SYNC);

  // A 1-bit divider is kept even for CLK_DIV=1; it then sits at 0 and the
  // tick is simply enable.
  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Each phase boundary must be a distinct count for the FSMs to see it.
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_total_check
    $error("vga_timing_ctrl: H_TOTAL and V_TOTAL must be <= 2048");
  end
  if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_param_check
    $error("vga_timing_ctrl: CLK_DIV and all timing segments must be >= 1");
  end

  typedef enum logic [1:0] {HP_ACT, HP_FP, HP_SYN, HP_BKP} h_phase_t;
  typedef enum logic [1:0] {VP_ACT, VP_FP, VP_SYN, VP_BKP} v_phase_t;

  logic [DIV_W-1:0] divider;
  h_phase_t         h_phase, h_next;
  v_phase_t         v_phase, v_next;
  logic [10:0]      x_next, y_next;
  logic             tick;

  assign tick        = enable && (divider == DIV_LAST);
  assign pixel_tick  = tick;
  assign line_end    = tick && (pixel_x == H_LAST);
  assign frame_start = tick && (pixel_x == 11'd0) && (pixel_y == 11'd0);

  // Next-state counters and phases. Registered outputs decode from these so
  // they line up with the coordinates they describe.
  always_comb begin
    x_next = pixel_x;
    y_next = pixel_y;
    h_next = h_phase;
    v_next = v_phase;
    if (tick) begin
      if (pixel_x == H_LAST) begin
        x_next = 11'd0;
        y_next = (pixel_y == V_LAST) ? 11'd0 : pixel_y + 11'd1;
      end else begin
        x_next = pixel_x + 11'd1;
      end

      case (h_phase)
        HP_ACT: if (x_next == H_FP_START)  h_next = HP_FP;
        HP_FP:  if (x_next == H_SYN_START) h_next = HP_SYN;
        HP_SYN: if (x_next == H_BP_START)  h_next = HP_BKP;
        HP_BKP: if (x_next == 11'd0)       h_next = HP_ACT;
        default: h_next = HP_ACT;
      endcase

      // The vertical phase only moves when the line wraps.
      if (pixel_x == H_LAST) begin
        case (v_phase)
          VP_ACT: if (y_next == V_FP_START)  v_next = VP_FP;
          VP_FP:  if (y_next == V_SYN_START) v_next = VP_SYN;
          VP_SYN: if (y_next == V_BP_START)  v_next = VP_BKP;
          VP_BKP: if (y_next == 11'd0)       v_next = VP_ACT;
          default: v_next = VP_ACT;
        endcase
      end
    end
  end

  // State and registered outputs. With enable low the next-state values equal
  // the current ones, so everything holds except video_on, which blanks.
  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      divider  <= '0;
      pixel_x  <= 11'd0;
      pixel_y  <= 11'd0;
      h_phase  <= HP_ACT;
      v_phase  <= VP_ACT;
      hsync    <= ~SYNC_POL;
      vsync    <= ~SYNC_POL;
      video_on <= 1'b0;
    end else begin
      if (enable) begin
        divider <= (divider == DIV_LAST) ? '0 : divider + 1'b1;
      end
      pixel_x  <= x_next;
      pixel_y  <= y_next;
      h_phase  <= h_next;
      v_phase  <= v_next;
      hsync    <= (h_next == HP_SYN) ? SYNC_POL : ~SYNC_POL;
      vsync    <= (v_next == VP_SYN) ? SYNC_POL : ~SYNC_POL;
      video_on <= enable && (h_next == HP_ACT) && (v_next == VP_ACT);
    end
  end

endmodule
